// File: rtl/aer_pkg.sv
// ============================================================================
//  aer_pkg : shared constants, event record and helpers for the AER encoder
//  Rev 1.0
// ============================================================================
`default_nettype none

package aer_pkg;

  localparam int unsigned c_N_CH  = 8;
  localparam int unsigned c_AW    = 3;
  localparam int unsigned c_DEPTH = 8;
  localparam int unsigned c_TSW   = 16;

  typedef struct packed {
    logic [c_AW-1:0]  addr;
    logic [c_TSW-1:0] ts;
  } aer_event_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    return (s > 32'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_aer_encoder_if.sv
// ============================================================================
//  spike_aer_encoder_if : valid/ready event bus carrying {addr, ts}
//  Rev 1.0
// ============================================================================
`default_nettype none

interface spike_aer_encoder_if
  import aer_pkg::*;
#(
  parameter int unsigned AW  = c_AW,
  parameter int unsigned TSW = c_TSW
);

  logic           ev_valid;
  logic           ev_ready;
  logic [AW-1:0]  ev_addr;
  logic [TSW-1:0] ev_ts;

  modport master (output ev_valid, output ev_addr, output ev_ts, input  ev_ready);
  modport slave  (input  ev_valid, input  ev_addr, input  ev_ts, output ev_ready);

endinterface

`default_nettype wire

// File: rtl/aer_fifo.sv
// ============================================================================
//  aer_fifo : synchronous show-ahead FIFO with occupancy count
//  Rev 1.0
// ============================================================================
`default_nettype none

module aer_fifo #(
  parameter int unsigned W     = 19,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !w_full;
  assign w_pop   = pop_i && !empty_o;
  assign count_o = count_q;
  // Head is forced to zero when empty so the bus never shows stale data.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + (PW+1)'(1);
      end else if (w_pop && !w_push) begin
        count_q <= count_q - (PW+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_aer_encoder.sv
// ============================================================================
//  spike_aer_encoder : spike edge detect, timestamping, round-robin AER queue
//  Rev 1.0
// ============================================================================
`default_nettype none

module spike_aer_encoder
  import aer_pkg::*;
#(
  parameter int unsigned N_CH  = c_N_CH,
  parameter int unsigned AW    = c_AW,
  parameter int unsigned DEPTH = c_DEPTH,
  parameter int unsigned TSW   = c_TSW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            spike_in,
  spike_aer_encoder_if.master        ev,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [TSW-1:0]  ts_q;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] pending_d;
  logic [TSW-1:0]  ts_hold_q [N_CH];
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_d;
  logic            overflow_q;
  logic [7:0]      drop_count_q;

  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_drop;
  logic [N_CH-1:0] w_grant_oh;
  logic            w_grant_vld;
  logic [AW-1:0]   w_grant_idx;
  logic [AW-1:0]   w_sel_idx;
  int unsigned     w_sel;
  int unsigned     w_drop_n;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_pop;

  // Round-robin search starting at ptr_q; a full FIFO blocks grants even if
  // a pop happens in the same cycle.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sel       = 0;
    w_sel_idx   = '0;
    if (w_fifo_count < CW'(DEPTH)) begin
      for (int off = 0; off < N_CH; off++) begin
        w_sel = 32'(ptr_q) + 32'(off);
        if (w_sel >= N_CH) begin
          w_sel = w_sel - N_CH;
        end
        w_sel_idx = AW'(w_sel);
        if (!w_grant_vld && pending_q[w_sel_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_sel_idx;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_grant_vld) begin
      ptr_d = (w_grant_idx == AW'(N_CH - 1)) ? '0 : w_grant_idx + AW'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      assign w_rise[i]     = spike_in[i] && !prev_q[i];
      assign w_grant_oh[i] = w_grant_vld && (w_grant_idx == AW'(i));
      // A channel granted this cycle frees its slot, so a coincident edge re-arms it.
      assign w_drop[i]     = w_rise[i] && pending_q[i] && !w_grant_oh[i];
      assign pending_d[i]  = w_rise[i] || (pending_q[i] && !w_grant_oh[i]);

      always_ff @(posedge clk) begin
        if (w_rise[i] && !w_drop[i]) begin
          ts_hold_q[i] <= ts_q;
        end
      end
    end
  endgenerate

  always_comb begin
    w_drop_n = 0;
    for (int k = 0; k < N_CH; k++) begin
      w_drop_n = w_drop_n + 32'(w_drop[k]);
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= spike_in;
    if (rst) begin
      ts_q         <= '0;
      pending_q    <= '0;
      ptr_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      ts_q         <= ts_q + TSW'(1);
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      if (|w_drop) begin
        overflow_q <= 1'b1;
      end
      drop_count_q <= sat_add8(drop_count_q, w_drop_n);
    end
  end

  assign w_pop = !w_fifo_empty && ev.ev_ready;

  aer_fifo #(
    .W     (AW + TSW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_grant_vld),
    .din_i   ({w_grant_idx, ts_hold_q[w_grant_idx]}),
    .pop_i   (w_pop),
    .dout_o  ({ev.ev_addr, ev.ev_ts}),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign ev.ev_valid = !w_fifo_empty;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
// ============================================================================
//  tb_spike_aer_encoder : directed stimulus with queue scoreboard and monitor
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spike_aer_encoder;

  localparam int unsigned N_CH  = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TSW   = 16;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [TSW-1:0] ts;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] spike_in = '0;
  logic            overflow;
  logic [7:0]      drop_count;
  logic [TSW-1:0]  tb_ts = '0;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  spike_aer_encoder_if #(.AW(AW), .TSW(TSW)) ev_if ();

  spike_aer_encoder #(
    .N_CH  (N_CH),
    .AW    (AW),
    .DEPTH (DEPTH),
    .TSW   (TSW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .ev         (ev_if),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT latches at the next edge.
  always @(posedge clk) tb_ts <= rst ? '0 : tb_ts + TSW'(1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int unsigned addr, input logic [TSW-1:0] ts);
    exp_t e;
    e.addr = AW'(addr);
    e.ts   = ts;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    tick();
    tick();
    check("rst_valid",    32'(ev_if.ev_valid), 32'd0);
    check("rst_addr",     32'(ev_if.ev_addr),  32'd0);
    check("rst_ts",       32'(ev_if.ev_ts),    32'd0);
    check("rst_overflow", 32'(overflow),       32'd0);
    check("rst_drops",    32'(drop_count),     32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((sb_q.size() != 0 || ev_if.ev_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(sb_q.size() == 0 && !ev_if.ev_valid), 32'd1);
  endtask

  task automatic wait_ts(input logic [TSW-1:0] target);
    int n = 0;
    while (tb_ts != target && n < 70000) begin
      tick();
      n++;
    end
  endtask

  task automatic monitor();
    logic           hold = 1'b0;
    logic [AW-1:0]  h_addr = '0;
    logic [TSW-1:0] h_ts = '0;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", 32'(ev_if.ev_valid), 32'd1);
          check("stall_addr",  32'(ev_if.ev_addr),  32'(h_addr));
          check("stall_ts",    32'(ev_if.ev_ts),    32'(h_ts));
        end
        if (ev_if.ev_valid && ev_if.ev_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: actual addr=%0h ts=%0h required none",
                     ev_if.ev_addr, ev_if.ev_ts);
          end else begin
            e = sb_q.pop_front();
            check("ev_addr", 32'(ev_if.ev_addr), 32'(e.addr));
            check("ev_ts",   32'(ev_if.ev_ts),   32'(e.ts));
          end
        end
        hold   = ev_if.ev_valid && !ev_if.ev_ready;
        h_addr = ev_if.ev_addr;
        h_ts   = ev_if.ev_ts;
      end
    end
  endtask

  initial begin
    ev_if.ev_ready = 1'b1;
    fork
      monitor();
    join_none

    // Single pulse on channel 5 at ts=10, held high for 20 cycles
    do_reset();
    wait_ts(16'd10);
    spike_in[5] = 1'b1;
    expect_ev(5, 16'd10);
    tick();
    check("lat_edge1_valid", 32'(ev_if.ev_valid), 32'd0);
    tick();
    check("lat_edge2_valid", 32'(ev_if.ev_valid), 32'd1);
    check("lat_head_addr",   32'(ev_if.ev_addr),  32'd5);
    check("lat_head_ts",     32'(ev_if.ev_ts),    32'd10);
    repeat (20) tick();
    spike_in[5] = 1'b0;
    wait_drain(10, "single_drain");

    // All eight low channels rise together at ts=3
    do_reset();
    wait_ts(16'd3);
    spike_in[7:0] = 8'hFF;
    for (int i = 0; i < 8; i++) expect_ev(i, 16'd3);
    wait_drain(10, "burst_drain");
    spike_in = '0;

    // Backpressure: 12 staggered edges, FIFO holds 8, 4 stay pending
    do_reset();
    ev_if.ev_ready = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      spike_in[i] = 1'b1;
      expect_ev(i, tb_ts);
      tick();
    end
    repeat (10) tick();
    check("bp_valid",    32'(ev_if.ev_valid), 32'd1);
    check("bp_head",     32'(ev_if.ev_addr),  32'd0);
    check("bp_head_ts",  32'(ev_if.ev_ts),    32'(sb_q[0].ts));
    check("bp_drops",    32'(drop_count),     32'd0);
    check("bp_overflow", 32'(overflow),       32'd0);
    ev_if.ev_ready = 1'b1;
    wait_drain(30, "bp_drain");
    spike_in = '0;

    // Drop: channel 2 re-pulses while pending and the FIFO is full
    do_reset();
    ev_if.ev_ready = 1'b0;
    tick();
    for (int i = 8; i < 16; i++) begin
      spike_in[i] = 1'b1;
      expect_ev(i, tb_ts);
      tick();
    end
    repeat (4) tick();
    spike_in[2] = 1'b1;
    expect_ev(2, tb_ts);
    tick();
    tick();
    spike_in[2] = 1'b0;
    tick();
    spike_in[2] = 1'b1;
    tick();
    check("drop_overflow", 32'(overflow),   32'd1);
    check("drop_count1",   32'(drop_count), 32'd1);
    ev_if.ev_ready = 1'b1;
    wait_drain(20, "drop_drain1");
    check("drop_count_kept", 32'(drop_count), 32'd1);

    ev_if.ev_ready = 1'b0;
    spike_in = '0;
    tick();
    tick();
    for (int i = 8; i < 16; i++) begin
      spike_in[i] = 1'b1;
      expect_ev(i, tb_ts);
      tick();
    end
    repeat (4) tick();
    spike_in[2] = 1'b1;
    expect_ev(2, tb_ts);
    tick();
    repeat (300) begin
      spike_in[2] = 1'b0;
      tick();
      spike_in[2] = 1'b1;
      tick();
    end
    check("drop_saturate", 32'(drop_count), 32'd255);
    check("drop_sticky",   32'(overflow),   32'd1);
    ev_if.ev_ready = 1'b1;
    wait_drain(20, "drop_drain2");

    // Reset with queued events and channel 0 held high across reset
    ev_if.ev_ready = 1'b0;
    spike_in = '0;
    tick();
    spike_in[0] = 1'b1;
    expect_ev(0, tb_ts);
    tick();
    spike_in[4] = 1'b1;
    expect_ev(4, tb_ts);
    tick();
    spike_in[5] = 1'b1;
    expect_ev(5, tb_ts);
    tick();
    repeat (3) tick();
    check("prerst_valid", 32'(ev_if.ev_valid), 32'd1);
    do_reset();
    ev_if.ev_ready = 1'b1;
    repeat (10) tick();
    check("postrst_valid", 32'(ev_if.ev_valid), 32'd0);
    spike_in[0] = 1'b0;
    tick();
    spike_in[0] = 1'b1;
    expect_ev(0, tb_ts);
    wait_drain(10, "postrst_drain");

    // Timestamp wrap: FFFF then 0000
    do_reset();
    spike_in = '0;
    wait_ts(16'hFFFF);
    spike_in[1] = 1'b1;
    expect_ev(1, 16'hFFFF);
    tick();
    spike_in[3] = 1'b1;
    expect_ev(3, 16'h0000);
    tick();
    wait_drain(10, "wrap_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameter N_CH, default 8, number of neuron axon inputs collected.
REQ-002 Parameter AW, default 3, event address width, SHALL equal clog2(N_CH).
REQ-003 Parameter DEPTH, default 8, event FIFO entries, power of two.
REQ-004 Parameter TSW, default 16, timestamp width.
REQ-005 Port clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port spike_in  in  N_CH  level axon outputs, one per neuron, synchronous to clk.
REQ-008 Port ev_valid  out  1  head event available.
REQ-009 Port ev_ready  in  1  consumer accepts head event.
REQ-010 Port ev_addr  out  AW  index of the spiking channel.
REQ-011 Port ev_ts  out  TSW  timestamp of the spike onset.
REQ-012 Port overflow  out  1  sticky, an event was dropped.
REQ-013 Port drop_count  out  8  saturating count of dropped events.

Function
REQ-014 Free-running timestamp counter SHALL increment every non-reset cycle, wrapping 2^TSW-1 -> 0.
REQ-015 Per channel, a rising edge (spike_in high, previous sample low) SHALL set pending[i] and latch the current timestamp into ts_hold[i]; a level held high SHALL produce exactly one event.
REQ-016 A rising edge on a channel whose pending bit is still set SHALL be dropped: ts_hold unchanged, overflow set, drop_count incremented (saturating at 255).
REQ-017 Round-robin arbiter SHALL grant at most one pending channel per cycle, searching upward (wrapping) from the channel after the last grant.
REQ-018 Grant SHALL occur only when FIFO count < DEPTH; a pop in the same cycle SHALL NOT enable a grant into a full FIFO.
REQ-019 On grant, {addr=i, ts=ts_hold[i]} SHALL be written to the FIFO and pending[i] cleared at the same edge; a new rising edge on i in that cycle SHALL re-set pending[i] (not a drop).
REQ-020 Latency: edge sampled at clock k -> pending at k -> FIFO write at k+1 -> ev_valid high after k+1 when FIFO otherwise empty and channel wins arbitration.
REQ-021 FIFO SHALL be show-ahead: ev_valid = not empty; ev_addr/ev_ts = head entry.
REQ-022 Pop SHALL occur on ev_valid && ev_ready; ev_addr/ev_ts SHALL remain stable while ev_valid && !ev_ready.
REQ-023 Simultaneous push and pop with count in 1..DEPTH-1 SHALL leave count unchanged; events leave in write order.
REQ-024 overflow and drop_count SHALL clear only on rst.

Reset
REQ-025 During rst: ev_valid=0, ev_addr=0, ev_ts=0, overflow=0, drop_count=0, FIFO empty, pending=0, timestamp=0, round-robin pointer so channel 0 has first priority.
REQ-026 During rst the previous-sample register SHALL load spike_in, so inputs held high across reset generate no event.
REQ-027 Reset asserted mid-operation SHALL discard all queued and pending events within the same edge.

Structure
REQ-028 Shared package aer_pkg SHALL hold default N_CH/AW/DEPTH/TSW constants and the event record typedef {addr, ts}.
REQ-029 FIFO SHALL be a separate sub-module aer_fifo (synchronous, show-ahead, count output); edge detect, pending, arbiter, timestamp stay in the top.

Verification
REQ-030 Single pulse: spike_in[5] 0->1 at ts=10, held 20 cycles, ev_ready=1 -> exactly one event addr=5 ts=10, ev_valid after 2 edges.
REQ-031 Simultaneous: spike_in 8'hFF rising at ts=3 -> eight events addr 0..7 in order, all ts=3, one per cycle.
REQ-032 Backpressure: ev_ready=0, 12 distinct channel edges with N_CH=16 -> 8 queued, 4 held pending, no drops; ev_addr/ev_ts stable; release ready -> all 12 delivered.
REQ-033 Drop: channel 2 re-pulses (fall then rise) while pending with FIFO full -> overflow=1, drop_count=1, only first ts delivered; 300 drops -> drop_count=255.
REQ-034 Reset: spike_in[0] held high through rst, 3 events queued before rst -> after rst ev_valid=0, no event for channel 0 until it falls and rises.
REQ-035 Wrap: edge at ts=16'hFFFF then next at 16'h0000 -> events carry FFFF then 0000.
